// File: rtl/memory_pkg.sv
// Shared definitions for the banked word memory: lane width, FSM states, lane parity.
package memory_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Even parity: the stored bit makes the 9-bit total an even number of ones.
    function automatic logic parity(input logic [LANE_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/memory_lane.sv
// One byte lane: DEPTH x 8 (x 9 with MEMORY_MODULE_BANKED_PARITY_EN) array, registered read-first port.
module memory_lane
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata,
    output logic              par_err
);

    localparam int unsigned DEPTH = 2**ADDR_W;

`ifdef MEMORY_MODULE_BANKED_PARITY_EN
    logic [LANE_W:0] mem [DEPTH];
    logic [LANE_W:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= {parity(wdata), wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd_q <= '0;
        else if (re) rd_q <= mem[addr];
    end

    assign rdata   = rd_q[LANE_W-1:0];
    assign par_err = ^rd_q;
`else
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd_q <= '0;
        else if (re) rd_q <= mem[addr];
    end

    assign rdata   = rd_q;
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/memory_module_banked.sv
// Banked byte-lane word memory with clear engine; optional lane parity via MEMORY_MODULE_BANKED_PARITY_EN.
module memory_module_banked
    import memory_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W/LANE_W-1:0] be,
    input  logic                     rE,
    input  logic                     wE,
    input  logic                     clr_req,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     rvalid,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned LANES = DATA_W / LANE_W;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rej_q;
    logic              clearing;
    logic              rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] lane_wdata;
    logic [LANES-1:0]  lane_we;
    logic [LANES-1:0]  lane_perr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
            rvalid  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rvalid <= rE;
                    rej_q  <= 1'b0;
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    rvalid  <= 1'b0;
                    rej_q   <= rE | wE;
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // While clearing, the lanes are driven by the counter with all-lane zero writes.
    always_comb begin
        clearing   = (state == ST_CLEAR);
        rd_en      = !clearing && rE;
        mem_addr   = clearing ? clr_cnt : address;
        lane_wdata = clearing ? '0 : data;
        lane_we    = clearing ? '1 : (wE ? be : '0);
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        memory_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk    (clock),
            .rst_n  (reset),
            .we     (lane_we[i]),
            .re     (rd_en),
            .addr   (mem_addr),
            .wdata  (lane_wdata[i*LANE_W +: LANE_W]),
            .rdata  (dataOut[i*LANE_W +: LANE_W]),
            .par_err(lane_perr[i])
        );
    end

    assign busy = (state == ST_CLEAR);
    assign err  = rej_q | (rvalid & (|lane_perr));

endmodule

// File: tb/tb_memory_module_banked.sv
// Bench for memory_module_banked: cycle-level reference model plus directed literal checks.
module tb_memory_module_banked;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] data;
    logic [AW-1:0] address;
    logic [3:0]    be;
    logic          rE, wE, clr_req;
    logic [DW-1:0] dataOut;
    logic          rvalid, busy, err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    memory_module_banked #(.DATA_W(DW), .ADDR_W(AW), .CLR_ON_RESET(1'b1)) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .address(address),
        .be     (be),
        .rE     (rE),
        .wE     (wE),
        .clr_req(clr_req),
        .dataOut(dataOut),
        .rvalid (rvalid),
        .busy   (busy),
        .err    (err)
    );

    always #5 clock = ~clock;

    // Reference model: busy_left counts remaining clear cycles.
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_dout;
    logic          exp_rv, exp_err;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_left = DEPTH;
            exp_dout  = '0;
            exp_rv    = 1'b0;
            exp_err   = 1'b0;
        end else if (busy_left > 0) begin
            exp_rv  = 1'b0;
            exp_err = rE | wE;
            mem_m[DEPTH - busy_left] = '0;
            busy_left = busy_left - 1;
        end else begin
            exp_err = 1'b0;
            exp_rv  = rE;
            if (rE) exp_dout = mem_m[address];
            if (wE)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_m[address][8*i +: 8] = data[8*i +: 8];
            if (clr_req) busy_left = DEPTH;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("model busy",    DW'(busy),   DW'(busy_left > 0));
            check("model rvalid",  DW'(rvalid), DW'(exp_rv));
            check("model err",     DW'(err),    DW'(exp_err));
            check("model dataOut", dataOut,     exp_dout);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        tick();
        address = a; data = d; be = b; wE = 1'b1;
        tick();
        wE = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        tick();
        address = a; rE = 1'b1;
        tick();
        rE = 1'b0;
        @(negedge clock);
        check({name, " data"},   dataOut,     exp);
        check({name, " rvalid"}, DW'(rvalid), 32'd1);
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (busy) n++;
            else break;
        end
        check(name, DW'(n), 32'd32);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("wait idle bound", DW'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; data = '0; address = '0; be = '0;
        rE = 1'b0; wE = 1'b0; clr_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_en = 1'b1;
        @(negedge clock);
        check("reset dataOut", dataOut,     32'h0);
        check("reset rvalid",  DW'(rvalid), 32'd0);
        check("reset busy",    DW'(busy),   32'd1);
        tick();
        reset = 1'b1;
        count_busy("busy after reset");

        do_read(5'd9, 32'h0000_0000, "post-clear read");

        do_write(5'd3, 32'hDEAD_BEEF, 4'b1111);
        do_write(5'd3, 32'h1122_3344, 4'b0101);
        do_read(5'd3, 32'hDE22_BE44, "lane merge");

        do_write(5'd7, 32'hA5A5_A5A5, 4'hF);
        tick();
        address = 5'd7; data = 32'h1234_5678; be = 4'hF; rE = 1'b1; wE = 1'b1;
        tick();
        rE = 1'b0; wE = 1'b0;
        @(negedge clock);
        check("read-first data", dataOut, 32'hA5A5_A5A5);
        do_read(5'd7, 32'h1234_5678, "after rw");

        do_write(5'd31, 32'hCAFE_F00D, 4'hF);
        do_write(5'd0, 32'hFFFF_FFFF, 4'h0);
        do_read(5'd0, 32'h0000_0000, "be=0 no-op");
        do_read(5'd31, 32'hCAFE_F00D, "addr31 stored");

        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (3) tick();
        address = 5'd0; data = 32'hFFFF_FFFF; be = 4'hF; wE = 1'b1; clr_req = 1'b1;
        tick();
        wE = 1'b0; clr_req = 1'b0;
        @(negedge clock);
        check("busy write err", DW'(err), 32'd1);
        tick();
        address = 5'd31; rE = 1'b1;
        tick();
        rE = 1'b0;
        wait_idle();
        do_read(5'd31, 32'h0000_0000, "addr31 cleared");
        do_read(5'd0, 32'h0000_0000, "addr0 cleared");

        do_write(5'd5, 32'h55AA_55AA, 4'hF);
        do_read(5'd5, 32'h55AA_55AA, "addr5 stored");
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        @(negedge clock);
        check("midclear rst dataOut", dataOut,     32'h0);
        check("midclear rst rvalid",  DW'(rvalid), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        count_busy("busy after mid-clear reset");
        do_read(5'd5, 32'h0000_0000, "addr5 cleared");

`ifdef MEMORY_MODULE_BANKED_PARITY_EN
        do_write(5'd4, 32'h0F0F_0F0F, 4'hF);
        check_en = 1'b0;
        dut.g_lane[2].u_lane.mem[4][3] = ~dut.g_lane[2].u_lane.mem[4][3];
        tick();
        address = 5'd4; rE = 1'b1;
        tick();
        rE = 1'b0;
        @(negedge clock);
        check("parity rvalid", DW'(rvalid), 32'd1);
        check("parity err",    DW'(err),    32'd1);
        check("parity data",   dataOut,     32'h0F07_0F0F);
`endif

        tick();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
